// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: instruction encodings,
// default latencies, decoded-op and FSM state enums, and the md decoder.
package mdu_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] F_MULT     = 6'b011000;
  localparam logic [5:0] F_MULTU    = 6'b011001;
  localparam logic [5:0] F_DIV      = 6'b011010;
  localparam logic [5:0] F_DIVU     = 6'b011011;
  localparam logic [5:0] F_MTHI     = 6'b010001;
  localparam logic [5:0] F_MTLO     = 6'b010011;
  localparam logic [5:0] F_MFHI     = 6'b010000;
  localparam logic [5:0] F_MFLO     = 6'b010010;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;
  localparam int CNT_W        = 16;

  typedef enum logic [3:0] {
    MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
    MD_MTHI, MD_MTLO, MD_MFHI, MD_MFLO
  } md_op_t;

  typedef enum logic {ST_IDLE, ST_BUSY} md_state_t;

  function automatic md_op_t md_decode(input logic [5:0] opcode, input logic [5:0] func);
    md_op_t op;
    op = MD_NONE;
    if (opcode == OP_SPECIAL) begin
      case (func)
        F_MULT:  op = MD_MULT;
        F_MULTU: op = MD_MULTU;
        F_DIV:   op = MD_DIV;
        F_DIVU:  op = MD_DIVU;
        F_MTHI:  op = MD_MTHI;
        F_MTLO:  op = MD_MTLO;
        F_MFHI:  op = MD_MFHI;
        F_MFLO:  op = MD_MFLO;
        default: op = MD_NONE;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing {hi,lo}.
// Divide paths exist only when MDU_DIV_EN is defined.
module md_arith
  import mdu_pkg::*;
(
  input  md_op_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] cur_hi,
  input  logic [31:0] cur_lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  always_comb begin
    res_hi = cur_hi;
    res_lo = cur_lo;
    case (op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
`ifdef MDU_DIV_EN
      // Divide by zero keeps the current hi/lo; the overflow case is pinned
      // explicitly so it never depends on simulator/synth division semantics.
      MD_DIV: begin
        if (b == 32'd0) begin
          res_hi = cur_hi;
          res_lo = cur_lo;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else begin
          res_lo = $signed(a) / $signed(b);
          res_hi = $signed(a) % $signed(b);
        end
      end
      MD_DIVU: begin
        if (b != 32'd0) begin
          res_lo = a / b;
          res_hi = a % b;
        end
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// Execute-stage multiply/divide controller: decode, latency FSM, HI/LO and
// D-stage stall. Define MDU_DIV_EN to enable div/divu; otherwise they are nops.
module md_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir_d,
  input  logic [31:0] ir_e,
  input  logic [31:0] numa,
  input  logic [31:0] numb,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] mdout,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      hi_reg, hi_next;
  logic [31:0]      lo_reg, lo_next;
  logic [31:0]      pend_hi_reg, pend_hi_next;
  logic [31:0]      pend_lo_reg, pend_lo_next;

  md_op_t      op_d, op_e;
  logic        start;
  logic        is_mul_e;
  logic [31:0] arith_hi, arith_lo;
  logic        unused_ir;

  function automatic md_op_t gate_op(input md_op_t op);
`ifdef MDU_DIV_EN
    return op;
`else
    return (op == MD_DIV || op == MD_DIVU) ? MD_NONE : op;
`endif
  endfunction

  assign op_d = gate_op(md_decode(ir_d[31:26], ir_d[5:0]));
  assign op_e = gate_op(md_decode(ir_e[31:26], ir_e[5:0]));
  assign unused_ir = ^{ir_d[25:6], ir_e[25:6]};

  assign is_mul_e = (op_e == MD_MULT) || (op_e == MD_MULTU);
  assign start = (is_mul_e || op_e == MD_DIV || op_e == MD_DIVU) && (state_reg == ST_IDLE);

  md_arith u_arith (
    .op     (op_e),
    .a      (numa),
    .b      (numb),
    .cur_hi (hi_reg),
    .cur_lo (lo_reg),
    .res_hi (arith_hi),
    .res_lo (arith_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      pend_hi_reg <= '0;
      pend_lo_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      pend_hi_reg <= pend_hi_next;
      pend_lo_reg <= pend_lo_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    pend_hi_next = pend_hi_reg;
    pend_lo_next = pend_lo_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next   = ST_BUSY;
          cnt_next     = is_mul_e ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
          pend_hi_next = arith_hi;
          pend_lo_next = arith_lo;
        end else if (op_e == MD_MTHI) begin
          hi_next = numa;
        end else if (op_e == MD_MTLO) begin
          lo_next = numa;
        end
      end
      ST_BUSY: begin
        // md instructions arriving in E while busy are dropped here.
        if (cnt_reg == CNT_W'(1)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          hi_next    = pend_hi_reg;
          lo_next    = pend_lo_reg;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_reg == ST_BUSY);
    stall_md = (op_d != MD_NONE) && (busy || start);
    hi       = hi_reg;
    lo       = lo_reg;
    case (op_e)
      MD_MFHI: mdout = hi_reg;
      MD_MFLO: mdout = lo_reg;
      default: mdout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed scoreboard bench for md_ctrl; expected hi/lo/latency are queued at
// issue and popped when busy falls. Div checks follow the MDU_DIV_EN build.
module tb_md_ctrl;
  import mdu_pkg::*;

  localparam int ML = 5;
  localparam int DL = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir_d, ir_e, numa, numb;
  logic        busy, stall_md;
  logic [31:0] mdout, hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic d_md = 1'b0;

  md_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk      (clk),
    .reset    (reset),
    .ir_d     (ir_d),
    .ir_e     (ir_e),
    .numa     (numa),
    .numb     (numb),
    .busy     (busy),
    .stall_md (stall_md),
    .mdout    (mdout),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] f);
    return {6'd0, 5'd4, 5'd5, 5'd2, 5'd0, f};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done();
    exp_t e;
    int   n;
    e = sb.pop_front();
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      chk("stall_busy", {31'd0, stall_md}, {31'd0, d_md});
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'(e.lat));
    chk("hi", hi, e.hi);
    chk("lo", lo, e.lo);
    chk("stall_after", {31'd0, stall_md}, 32'd0);
  endtask

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int lat);
    exp_t e;
    e.hi = eh;
    e.lo = el;
    e.lat = lat;
    sb.push_back(e);
    ir_e = mk(f);
    numa = a;
    numb = b;
    #1;
    chk("stall_start", {31'd0, stall_md}, {31'd0, d_md});
    tick();
    ir_e = 32'd0;
    numa = 32'd0;
    numb = 32'd0;
    chk("busy_set", {31'd0, busy}, 32'd1);
    wait_done();
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] p;

    reset = 1'b1;
    ir_d = 32'd0;
    ir_e = 32'd0;
    numa = 32'd0;
    numb = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall_md}, 32'd0);
    chk("rst_mdout", mdout, 32'd0);

    run_op(F_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, ML);

    // multu with mflo waiting in D: stalled until busy drops, then reads LO
    ir_d = mk(F_MFLO);
    d_md = 1'b1;
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, ML);
    ir_e = ir_d;
    ir_d = 32'd0;
    d_md = 1'b0;
    #1;
    chk("mflo_mdout", mdout, 32'h0000_0001);
    tick();
    ir_e = 32'd0;

    // mthi / mtlo with the matching move-from in D: no stall, value next cycle
    ir_d = mk(F_MFHI);
    ir_e = mk(F_MTHI);
    numa = 32'h0000_1234;
    #1;
    chk("mthi_stall", {31'd0, stall_md}, 32'd0);
    tick();
    ir_e = ir_d;
    ir_d = mk(F_MFLO);
    numa = 32'd0;
    #1;
    chk("mthi_hi", hi, 32'h0000_1234);
    chk("mfhi_mdout", mdout, 32'h0000_1234);
    chk("mfhi_stall", {31'd0, stall_md}, 32'd0);
    tick();
    ir_e = mk(F_MTLO);
    numa = 32'h0000_ABCD;
    tick();
    ir_e = ir_d;
    ir_d = 32'd0;
    numa = 32'd0;
    #1;
    chk("mtlo_lo", lo, 32'h0000_ABCD);
    chk("mflo_mdout2", mdout, 32'h0000_ABCD);
    tick();
    ir_e = 32'd0;

`ifdef MDU_DIV_EN
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DL);
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DL);
    run_op(F_DIVU, 32'd5, 32'd0, 32'h0000_0000, 32'h8000_0000, DL);
    ir_e = mk(F_DIV);
`else
    // div is a nop in this build: no busy, no stall, hi/lo untouched
    ir_d = mk(F_MFLO);
    ir_e = mk(F_DIV);
    numa = 32'd10;
    numb = 32'd3;
    #1;
    chk("nodiv_stall0", {31'd0, stall_md}, 32'd0);
    tick();
    ir_e = 32'd0;
    for (int i = 0; i < 12; i++) begin
      chk("nodiv_busy", {31'd0, busy}, 32'd0);
      chk("nodiv_stall", {31'd0, stall_md}, 32'd0);
      tick();
    end
    chk("nodiv_hi", hi, 32'h0000_1234);
    chk("nodiv_lo", lo, 32'h0000_ABCD);
    ir_d = 32'd0;
    ir_e = mk(F_MULT);
`endif

    // reset in the third busy cycle aborts the operation
    numa = 32'd100;
    numb = 32'd7;
    tick();
    ir_e = 32'd0;
    numa = 32'd0;
    numb = 32'd0;
    tick();
    tick();
    chk("abort_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    ir_d = mk(F_MFHI);
    tick();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_stall", {31'd0, stall_md}, 32'd0);
    reset = 1'b0;
    ir_d = 32'd0;
    repeat (12) tick();
    chk("abort_hi_late", hi, 32'd0);
    chk("abort_lo_late", lo, 32'd0);
    chk("abort_busy_late", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 0) begin
        p = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
        run_op(F_MULT, ra, rb, p[63:32], p[31:0], ML);
      end else begin
        p = {32'd0, ra} * {32'd0, rb};
        run_op(F_MULTU, ra, rb, p[63:32], p[31:0], ML);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
